// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven sequencer for the calculator datapath.
// Holds the two-entry operand stack (A, B), hands arithmetic to the ALU over a
// start/ready handshake and moves values to/from the register file.
module calc_sequencer #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      NREGS        = 10,
    parameter logic [WIDTH-1:0] ERR_VAL      = WIDTH'(8'h7F),
    parameter int unsigned      CALC_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       tecla,
    input  logic             tecla_valid,
    output logic             key,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             subtract,
    output logic             calc_start,
    input  logic             ready,
    input  logic [WIDTH-1:0] calcresult,
    input  logic             overflow,
    output logic [3:0]       regadress,
    output logic             regwrite,
    output logic [WIDTH-1:0] regstore,
    output logic             regread,
    input  logic [WIDTH-1:0] regload,
    output logic             ok
);

    localparam int unsigned CNT_W = $clog2(CALC_TIMEOUT + 1);

    localparam logic [3:0] K_DIGIT_MAX = 4'd9;
    localparam logic [3:0] K_ADD       = 4'd10;
    localparam logic [3:0] K_SUB       = 4'd11;
    localparam logic [3:0] K_STORE     = 4'd12;
    localparam logic [3:0] K_LOAD      = 4'd13;
    localparam logic [3:0] K_ENTER     = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CALC      = 3'd1,
        S_STORE     = 3'd2,
        S_LOAD_WAIT = 3'd3,
        S_LOAD_CAP  = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ok;
    logic             r_sub;
    logic             r_start;
    logic             r_wr;
    logic             r_rd;
    logic [3:0]       r_adr;
    logic [WIDTH-1:0] r_store;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_ok_nxt;
    logic             w_sub_nxt;
    logic             w_start_nxt;
    logic             w_wr_nxt;
    logic             w_rd_nxt;
    logic [3:0]       w_adr_nxt;
    logic [WIDTH-1:0] w_store_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_addr_ok;

    // B must name an existing register-file entry (full-width unsigned compare)
    assign w_addr_ok = (r_b < WIDTH'(NREGS));

    // Next-state and next-register logic
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_ok_nxt    = r_ok;
        w_sub_nxt   = r_sub;
        w_start_nxt = 1'b0;
        w_wr_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
        w_adr_nxt   = r_adr;
        w_store_nxt = r_store;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (tecla_valid) begin
                    if (tecla <= K_DIGIT_MAX) begin
                        w_b_nxt  = WIDTH'(tecla);
                        w_ok_nxt = 1'b1;
                    end else if (tecla == K_ADD || tecla == K_SUB) begin
                        w_sub_nxt   = (tecla == K_SUB);
                        w_start_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_ok_nxt    = 1'b1;
                        w_state_nxt = S_CALC;
                    end else if (tecla == K_STORE || tecla == K_LOAD) begin
                        if (w_addr_ok) begin
                            w_adr_nxt = r_b[3:0];
                            w_ok_nxt  = 1'b1;
                            if (tecla == K_STORE) begin
                                w_store_nxt = r_a;
                                w_wr_nxt    = 1'b1;
                                w_state_nxt = S_STORE;
                            end else begin
                                w_rd_nxt    = 1'b1;
                                w_state_nxt = S_LOAD_WAIT;
                            end
                        end else begin
                            w_a_nxt  = ERR_VAL;
                            w_b_nxt  = ERR_VAL;
                            w_ok_nxt = 1'b0;
                        end
                    end else if (tecla == K_ENTER) begin
                        w_a_nxt  = r_b;
                        w_ok_nxt = 1'b1;
                    end else begin
                        w_ok_nxt = 1'b1;
                    end
                end
            end

            S_CALC: begin
                // ready takes priority over a coincident timeout
                if (ready) begin
                    if (overflow) begin
                        w_a_nxt  = ERR_VAL;
                        w_b_nxt  = ERR_VAL;
                        w_ok_nxt = 1'b0;
                    end else begin
                        w_a_nxt  = '0;
                        w_b_nxt  = calcresult;
                        w_ok_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CNT_W'(CALC_TIMEOUT - 1)) begin
                    w_a_nxt     = ERR_VAL;
                    w_b_nxt     = ERR_VAL;
                    w_ok_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_STORE: begin
                w_state_nxt = S_IDLE;
            end

            S_LOAD_WAIT: begin
                w_state_nxt = S_LOAD_CAP;
            end

            S_LOAD_CAP: begin
                w_b_nxt     = regload;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_ok    <= 1'b1;
            r_sub   <= 1'b0;
            r_start <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_adr   <= '0;
            r_store <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_ok    <= w_ok_nxt;
            r_sub   <= w_sub_nxt;
            r_start <= w_start_nxt;
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_adr   <= w_adr_nxt;
            r_store <= w_store_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign key        = (r_state == S_IDLE);
    assign A          = r_a;
    assign B          = r_b;
    assign ok         = r_ok;
    assign subtract   = r_sub;
    assign calc_start = r_start;
    assign regwrite   = r_wr;
    assign regread    = r_rd;
    assign regadress  = r_adr;
    assign regstore   = r_store;

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Clocked sequencer for the calculator datapath. It accepts keypad codes and maintains the two-entry operand stack (A = queue[1], B = queue[0]). It drives the adder/subtractor through a start/ready handshake and the 10-entry register file through single-cycle write and read pulses. It sits between the keypad decoder and the ALU/register file, and A/B also feed the display.

Parameters:
WIDTH, 8, operand/result width
NREGS, 10, number of register-file entries; valid addresses 0..NREGS-1
ERR_VAL, 8'h7F, value loaded into A and B on any error
CALC_TIMEOUT, 64, max cycles spent in CALC waiting for ready before error

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tecla  in  4  key code; qualified by tecla_valid
tecla_valid  in  1  one-cycle key strobe
key  out  1  high when the sequencer accepts a key (state IDLE)
A  out  WIDTH  stack entry 1
B  out  WIDTH  stack entry 0
subtract  out  1  ALU mode: 0 = A+B, 1 = A-B; stable while the op is in flight
calc_start  out  1  one-cycle ALU start pulse
ready  in  1  ALU done strobe; qualifies calcresult and overflow
calcresult  in  WIDTH  ALU result
overflow  in  1  ALU overflow flag, sampled with ready
regadress  out  4  register-file address
regwrite  out  1  one-cycle write pulse
regstore  out  WIDTH  write data
regread  out  1  one-cycle read pulse
regload  in  WIDTH  read data, valid the cycle after regread
ok  out  1  low after an error; high otherwise

Behaviour:
- All outputs are registered except key, which is (state == IDLE).
- Reset values: state IDLE, A = 0, B = 0, ok = 1, subtract = 0, calc_start = 0, regwrite = 0, regread = 0, regadress = 0, regstore = 0, timeout counter = 0.
- Reset asserted in any state returns to IDLE next cycle. An in-flight ALU or register transaction is abandoned; a late ready is ignored.
- States: IDLE, CALC, STORE, LOAD_WAIT, LOAD_CAP.
- IDLE acts only on tecla_valid. tecla_valid outside IDLE is dropped with no side effect. ready in IDLE is ignored.
- Codes 0..9: B <= zero-extended digit; ok <= 1.
- Code 10 (sum): subtract <= 0; calc_start pulses 1 cycle; go to CALC.
- Code 11 (subtract): subtract <= 1; calc_start pulses 1 cycle; go to CALC.
- Code 12 (store):
  - if B >= NREGS: error.
  - else regadress <= B[3:0], regstore <= A, regwrite pulses 1 cycle; go to STORE; STORE returns to IDLE next cycle.
  - A and B are unchanged.
- Code 13 (load):
  - if B >= NREGS: error.
  - else regadress <= B[3:0], regread pulses 1 cycle; go to LOAD_WAIT, then LOAD_CAP.
  - In LOAD_CAP: B <= regload; return to IDLE.
  - Key-to-B latency is 3 cycles.
- Code 14 (enter): A <= B.
- Code 15: no-op; ok <= 1.
- Every non-erroring accepted key sets ok <= 1.
- Error action (single cycle, stays/returns IDLE): A <= ERR_VAL, B <= ERR_VAL, ok <= 0.
- CALC:
  - A, B and subtract are held stable; the counter increments each cycle.
  - On ready with overflow = 0: B <= calcresult, A <= 0, ok <= 1; go to IDLE.
  - On ready with overflow = 1: error action; go to IDLE.
  - Counter reaching CALC_TIMEOUT with no ready: error action; go to IDLE.
  - ready in the same cycle as timeout: ready wins.
  - The counter clears on CALC entry.
- calc_start, regwrite and regread are never high for more than one consecutive cycle. At most one of them is high in any cycle.
- Arithmetic is done entirely by the ALU; the sequencer performs no width extension beyond digit zero-extension. Address compare is an unsigned compare on the full WIDTH of B.

Test Plan:
- Reset then key 5, key 14, key 3, key 10; ALU returns ready with calcresult = 8 and overflow = 0 after 4 cycles -> calc_start pulses once with A = 5, B = 3, subtract = 0; final A = 0, B = 8, ok = 1, key = 1.
- A = 2, B = 9, key 11; ALU ready with overflow = 1 -> subtract = 1 held through CALC; after ready A = B = 8'h7F, ok = 0. Next key 4 -> B = 4, ok = 1.
- A = 7, B = 3, key 12 -> exactly one regwrite cycle with regadress = 3, regstore = 7; A and B unchanged. Then B = 3, key 13 with regload = 7 -> regread pulses once; B = 7 three cycles after the key.
- B = 12, key 12 then B = 12, key 13 -> no regwrite or regread pulse; A = B = 8'h7F, ok = 0.
- Key 10 with ready never asserted -> after CALC_TIMEOUT = 64 cycles A = B = 8'h7F, ok = 0, back in IDLE. Keys strobed during CALC have no effect.
- Reset asserted 2 cycles into CALC, ready arriving 1 cycle later -> A = B = 0, ok = 1, state IDLE; the late ready causes no change.
